synapse_array: RTL and testbench
================================

Name: synapse_array

Overview:
- Time-multiplexed array of N_SYN conductance-based synapses driving one dendrite compartment.
- One arithmetic datapath services one channel per clk in round-robin order. It decays and increments each channel's conductance and sums the channel currents into a single frame current.
- Spikes arriving between services are latched. Per-channel E_rev, weight and tau_syn load over a daisy-chained config shift register.

Parameters:
- N_SYN, 4, number of synapse channels (>=2).
- WORD_LENGTH, 16, width of conductance, weight, tau, E_rev, vmem and current words.
- SHIFT_DECAY, 15, right shift applied to gsyn*tau_syn.
- SHIFT_CURRENT, 9, arithmetic right shift applied to (E_rev-vmem)*gsyn.

Ports:
- clk  in  1  datapath clock
- reset  in  1  synchronous, active-high
- input_spike  in  N_SYN  per-channel spike, level sampled every clk
- vmem  in  WORD_LENGTH  dendrite membrane potential, two's complement
- output_current  out  WORD_LENGTH  frame-summed synaptic current, two's complement, saturated
- cur_valid  out  1  one-cycle pulse when output_current updates
- spike_merged  out  1  one-cycle pulse when a spike coalesces with an unserviced one
- cfg_clk  in  1  config shift clock
- cfg_in  in  WORD_LENGTH  config chain input
- cfg_out  out  WORD_LENGTH  config chain output, to the next block

Behaviour:
- Interface: reset is synchronous, active-high; the clock is clk.
- Reset values:
  - output_current=0, cur_valid=0, spike_merged=0.
  - All gsyn[i]=0, pending[i]=0, channel counter ch=0, accumulator=0.
  - Config registers and cfg_out are not reset.
- Scheduler: ch increments 0..N_SYN-1 every clk and wraps to 0. One frame = N_SYN cycles.
- Spike capture:
  - For i != ch: pending[i] <= pending[i] | input_spike[i].
  - spike_merged pulses in the next cycle if pending[i] is already set and input_spike[i]=1 (for any i, including i=ch).
- Service of channel ch:
  - Effective spike s = pending[ch] | input_spike[ch]. pending[ch] clears.
  - decay = (gsyn*tau_syn) >> SHIFT_DECAY, unsigned. The full 2*WORD_LENGTH product is taken before the shift.
  - If tau_syn==0: no decay, gsyn held.
  - Else if s=0, gsyn>0, and (decay==0 or gsyn==1): gsyn <= 0 (floor).
  - Else: gsyn <= gsyn - decay + (s ? weight : 0), unsigned, saturating at 2^WORD_LENGTH-1. Decay never exceeds gsyn.
- Current of channel ch uses the pre-update gsyn[ch]:
  - diff = E_rev - vmem, computed as (WORD_LENGTH+1)-bit signed.
  - prod = diff * {0,gsyn}, signed (2*WORD_LENGTH+2 bits).
  - term = prod >>> SHIFT_CURRENT.
  - term is added to a signed accumulator of width 2*WORD_LENGTH+2+clog2(N_SYN); the accumulator never overflows.
- Frame end:
  - On the cycle ch==N_SYN-1, the accumulator plus the last term is saturated to the signed WORD_LENGTH range [-2^(W-1), 2^(W-1)-1].
  - The saturated value registers into output_current with cur_valid=1 on the next cycle. The accumulator restarts from 0 that cycle.
- Latency: a spike serviced at cycle t updates gsyn at t+1. Its current first appears in the next frame's output_current.
- vmem is sampled in each service cycle; it is not frozen per frame.
- Config chain, clocked on cfg_clk posedge:
  - Chain order: cfg_in -> E_rev[0] -> weight[0] -> tau[0] -> E_rev[1] -> ... -> tau[N_SYN-1] -> cfg_out.
  - The chain is 3*N_SYN words deep; the first word shifted in ends in tau[N_SYN-1].
  - Config is quasi-static: written only while the datapath is idle or in reset. There is no CDC logic.
- Reset mid-frame: partial sum is discarded, pending spikes are lost, next frame starts at ch=0.

Decomposition:
- Shared package fp: WORD_LENGTH, fpType, fpWideType, and saturating-add/clamp functions.
- Sub-module synapse_channel_update (combinational): gsyn, tau, weight, s in; new_gsyn and current term out.
- synapse_array holds only the storage, scheduler, spike latch, accumulator and config chain.

Test Plan (N_SYN=4, defaults):
- Ch0: E_rev=0x1000, weight=0x0100, tau=0, vmem=0; one spike on ch0 -> gsyn0=0x0100; next frame output_current=0x0800, cur_valid pulse every 4 cycles.
- Decay: gsyn0=0x8000 via weight, tau0=0x4000, no spikes -> gsyn0 = 0x4000, 0x2000, ... on successive services; reaches 0 with no stall at 1.
- Saturation: weight1=0xFFFF, tau1=0, spikes on two services -> gsyn1=0xFFFF. E_rev1=0x7FFF, vmem=0x8000 -> output_current=0x7FFF.
- Negative current: E_rev0=0, vmem=0x1000, gsyn0=0x0100, other channels gsyn=0 -> output_current=0xF800.
- Merge: two ch2 spikes before its service -> gsyn2 increments by weight once; spike_merged pulses once. A spike on ch2's own service cycle is applied in that service.
- Config: shift words 1..12 -> tau[3]=1, E_rev[0]=12. cfg_out shows word 1 after the 12th shift. Reset mid-frame -> output_current=0, no cur_valid until 4 cycles after reset release.

Source files
------------

// File: rtl/fp_pkg.sv
// ----------------------------------------------------------------------------
// fp: shared fixed-point definitions for the synapse datapath.
//   WORD_LENGTH    - default width of conductance / weight / tau / E_rev /
//                    vmem / current words
//   fpType         - one unsigned/two's-complement data word
//   fpWideType     - full-precision product of two data words
//   sat_unsigned() - clamp a value into [0, 2^width-1]
//   clamp_signed() - clamp a value into [-2^(width-1), 2^(width-1)-1]
// The helpers work on longint so one function serves every operand width the
// datapath uses (all well below 64 bits).
// ----------------------------------------------------------------------------
package fp;

    localparam int WORD_LENGTH = 16;

    typedef logic [WORD_LENGTH-1:0]   fpType;
    typedef logic [2*WORD_LENGTH-1:0] fpWideType;

    function automatic longint sat_unsigned(input longint value, input int width);
        longint max_val;
        max_val = (64'sd1 <<< width) - 64'sd1;
        if (value > max_val)
            return max_val;
        else if (value < 64'sd0)
            return 64'sd0;
        else
            return value;
    endfunction

    function automatic longint clamp_signed(input longint value, input int width);
        longint max_val;
        longint min_val;
        max_val = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_val = -max_val - 64'sd1;
        if (value > max_val)
            return max_val;
        else if (value < min_val)
            return min_val;
        else
            return value;
    endfunction

endpackage

// File: rtl/synapse_channel_update.sv
// ----------------------------------------------------------------------------
// synapse_channel_update: combinational per-channel arithmetic, shared by all
// channels of synapse_array through time multiplexing.
//   gsyn      in  current conductance of the serviced channel (unsigned)
//   tau       in  decay factor; 0 disables decay
//   weight    in  conductance increment applied on a spike
//   e_rev     in  reversal potential (two's complement)
//   vmem      in  membrane potential (two's complement)
//   s         in  effective spike for this service
//   new_gsyn  out conductance after decay and increment (saturating)
//   term      out (e_rev - vmem) * gsyn >>> SHIFT_CURRENT, from pre-update gsyn
// ----------------------------------------------------------------------------
module synapse_channel_update
    import fp::*;
#(
    parameter int WORD_LENGTH   = fp::WORD_LENGTH,
    parameter int SHIFT_DECAY   = 15,
    parameter int SHIFT_CURRENT = 9
) (
    input  logic [WORD_LENGTH-1:0]          gsyn,
    input  logic [WORD_LENGTH-1:0]          tau,
    input  logic [WORD_LENGTH-1:0]          weight,
    input  logic [WORD_LENGTH-1:0]          e_rev,
    input  logic [WORD_LENGTH-1:0]          vmem,
    input  logic                            s,
    output logic [WORD_LENGTH-1:0]          new_gsyn,
    output logic signed [2*WORD_LENGTH+1:0] term
);

    localparam int W  = WORD_LENGTH;
    localparam int PW = 2 * WORD_LENGTH + 2;

    logic [2*W-1:0]        decay_prod;
    logic [2*W-1:0]        decay_full;
    logic [W-1:0]          decay;
    logic [W-1:0]          inc;
    logic [W:0]            sum;
    longint                sat_val;
    logic                  floor_hit;
    logic signed [W:0]     diff;
    logic signed [PW-1:0]  prod;

    // NOTE: every variable written here gets a value before any branch, so no
    // path leaves it holding its old value and no latch is inferred.
    always_comb begin
        decay_prod = {{W{1'b0}}, gsyn} * {{W{1'b0}}, tau};
        decay_full = decay_prod >> SHIFT_DECAY;

        // Large tau could make the shifted product exceed gsyn; never let the
        // subtraction underflow.
        if (tau == '0)
            decay = '0;
        else if (decay_full > {{W{1'b0}}, gsyn})
            decay = gsyn;
        else
            decay = W'(decay_full);

        inc     = s ? weight : '0;
        sum     = {1'b0, gsyn} - {1'b0, decay} + {1'b0, inc};
        sat_val = sat_unsigned(longint'(sum), W);

        // Without this floor a small conductance whose decay rounds to zero
        // would stick forever instead of relaxing to rest.
        floor_hit = (tau != '0) && !s && (gsyn != '0) &&
                    ((decay_full == '0) || (gsyn == W'(1)));

        new_gsyn = floor_hit ? '0 : W'(sat_val);

        diff = $signed({e_rev[W-1], e_rev}) - $signed({vmem[W-1], vmem});
        prod = $signed({{(W+1){diff[W]}}, diff}) * $signed({{(W+2){1'b0}}, gsyn});
        term = prod >>> SHIFT_CURRENT;
    end

endmodule

// File: rtl/synapse_array.sv
// ----------------------------------------------------------------------------
// synapse_array: N_SYN time-multiplexed conductance synapses feeding one
// dendrite. One channel is serviced per clk in round-robin order; the channel
// currents of one frame (N_SYN cycles) are summed and published once a frame.
//   clk             in  datapath clock
//   reset           in  synchronous, active-high
//   input_spike     in  per-channel spike level, sampled every clk
//   vmem            in  membrane potential, sampled in each service cycle
//   output_current  out saturated frame current (two's complement)
//   cur_valid       out one-cycle pulse when output_current updates
//   spike_merged    out one-cycle pulse when a spike lands on a pending one
//   cfg_clk         in  config shift clock
//   cfg_in          in  config chain input
//   cfg_out         out config chain output, to the next block
// Config chain order: cfg_in -> E_rev[0] -> weight[0] -> tau[0] -> E_rev[1]
// -> ... -> tau[N_SYN-1] -> cfg_out. Config changes only while the datapath
// is idle or in reset, so the two clock domains need no synchronisers.
// ----------------------------------------------------------------------------
module synapse_array
    import fp::*;
#(
    parameter int N_SYN         = 4,
    parameter int WORD_LENGTH   = fp::WORD_LENGTH,
    parameter int SHIFT_DECAY   = 15,
    parameter int SHIFT_CURRENT = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_SYN-1:0]       input_spike,
    input  logic [WORD_LENGTH-1:0] vmem,
    output logic [WORD_LENGTH-1:0] output_current,
    output logic                   cur_valid,
    output logic                   spike_merged,
    input  logic                   cfg_clk,
    input  logic [WORD_LENGTH-1:0] cfg_in,
    output logic [WORD_LENGTH-1:0] cfg_out
);

    localparam int W     = WORD_LENGTH;
    localparam int CH_W  = $clog2(N_SYN);
    localparam int PW    = 2 * WORD_LENGTH + 2;
    localparam int ACC_W = PW + $clog2(N_SYN);
    localparam int CHAIN = 3 * N_SYN;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_SYN - 1);

    // ---------------- config chain ----------------
    logic [W-1:0] cfg_chain [CHAIN];

    // NOTE: the config chain is plain storage with no reset; it is always
    // fully reloaded by shifting, so a reset would only cost routing.
    always_ff @(posedge cfg_clk) begin
        cfg_chain[0] <= cfg_in;
        for (int k = 1; k < CHAIN; k++)
            cfg_chain[k] <= cfg_chain[k-1];
    end

    assign cfg_out = cfg_chain[CHAIN-1];

    // ---------------- datapath state ----------------
    logic [CH_W-1:0]         ch;
    logic [W-1:0]            gsyn [N_SYN];
    logic [N_SYN-1:0]        pending;
    logic signed [ACC_W-1:0] acc;

    logic [N_SYN-1:0]        ch_onehot;
    logic [W-1:0]            sel_gsyn;
    logic [W-1:0]            sel_e_rev;
    logic [W-1:0]            sel_weight;
    logic [W-1:0]            sel_tau;
    logic                    eff_spike;
    logic [W-1:0]            new_gsyn;
    logic signed [PW-1:0]    term;
    logic signed [ACC_W-1:0] acc_sum;
    longint                  sat_val;

    always_comb begin
        ch_onehot  = '0;
        sel_gsyn   = '0;
        sel_e_rev  = '0;
        sel_weight = '0;
        sel_tau    = '0;
        eff_spike  = 1'b0;
        for (int i = 0; i < N_SYN; i++) begin
            if (ch == CH_W'(i)) begin
                ch_onehot[i] = 1'b1;
                sel_gsyn     = gsyn[i];
                sel_e_rev    = cfg_chain[3*i];
                sel_weight   = cfg_chain[3*i+1];
                sel_tau      = cfg_chain[3*i+2];
                // A spike arriving on the service cycle itself is used now.
                eff_spike    = pending[i] | input_spike[i];
            end
        end
        acc_sum = acc + ACC_W'(term);
        sat_val = clamp_signed(longint'(acc_sum), W);
    end

    synapse_channel_update #(
        .WORD_LENGTH  (WORD_LENGTH),
        .SHIFT_DECAY  (SHIFT_DECAY),
        .SHIFT_CURRENT(SHIFT_CURRENT)
    ) u_update (
        .gsyn    (sel_gsyn),
        .tau     (sel_tau),
        .weight  (sel_weight),
        .e_rev   (sel_e_rev),
        .vmem    (vmem),
        .s       (eff_spike),
        .new_gsyn(new_gsyn),
        .term    (term)
    );

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this edge, whatever the statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch             <= '0;
            pending        <= '0;
            acc            <= '0;
            output_current <= '0;
            cur_valid      <= 1'b0;
            spike_merged   <= 1'b0;
            for (int i = 0; i < N_SYN; i++)
                gsyn[i] <= '0;
        end else begin
            ch           <= (ch == LAST_CH) ? '0 : ch + CH_W'(1);
            pending      <= (pending | input_spike) & ~ch_onehot;
            spike_merged <= |(pending & input_spike);
            for (int i = 0; i < N_SYN; i++)
                if (ch_onehot[i])
                    gsyn[i] <= new_gsyn;
            if (ch == LAST_CH) begin
                output_current <= W'(sat_val);
                cur_valid      <= 1'b1;
                acc            <= '0;
            end else begin
                acc       <= acc_sum;
                cur_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_synapse_array.sv
// ----------------------------------------------------------------------------
// tb_synapse_array: directed-vector bench for synapse_array (N_SYN=4, 16-bit).
// Each scenario configures the chain under reset, releases reset on a falling
// edge so the next rising edge services channel 0, and then runs whole frames
// with a per-cycle spike pattern, checking cur_valid every cycle and
// output_current at each frame end.
// ----------------------------------------------------------------------------
module tb_synapse_array;
    import fp::*;

    logic        clk;
    logic        reset;
    logic [3:0]  input_spike;
    fpType       vmem;
    fpType       output_current;
    logic        cur_valid;
    logic        spike_merged;
    logic        cfg_clk;
    fpType       cfg_in;
    fpType       cfg_out;

    int n_total = 0;
    int n_bad   = 0;

    synapse_array #(
        .N_SYN        (4),
        .WORD_LENGTH  (16),
        .SHIFT_DECAY  (15),
        .SHIFT_CURRENT(9)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .input_spike   (input_spike),
        .vmem          (vmem),
        .output_current(output_current),
        .cur_valid     (cur_valid),
        .spike_merged  (spike_merged),
        .cfg_clk       (cfg_clk),
        .cfg_in        (cfg_in),
        .cfg_out       (cfg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clk; return on the falling edge with outputs settled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cfg_shift(input fpType word);
        cfg_in = word;
        #2 cfg_clk = 1'b1;
        #2 cfg_clk = 1'b0;
    endtask

    // Packed arguments hold channel i in bits [16*i +: 16].
    task automatic start(input logic [63:0] e, input logic [63:0] w, input logic [63:0] t);
        reset       = 1'b1;
        input_spike = '0;
        for (int i = 3; i >= 0; i--) begin
            cfg_shift(t[16*i +: 16]);
            cfg_shift(w[16*i +: 16]);
            cfg_shift(e[16*i +: 16]);
        end
        step();
        step();
    endtask

    // One frame; spikes[4*c +: 4] is driven during cycle c of the frame.
    task automatic run_frame(input string tag, input fpType exp, input logic [15:0] spikes);
        for (int c = 0; c < 4; c++) begin
            input_spike = spikes[4*c +: 4];
            step();
            if (c < 3) begin
                check($sformatf("%s_valid%0d", tag, c), {31'd0, cur_valid}, 32'd0);
            end else begin
                check($sformatf("%s_valid%0d", tag, c), {31'd0, cur_valid}, 32'd1);
                check($sformatf("%s_cur", tag), {16'd0, output_current}, {16'd0, exp});
            end
        end
        input_spike = '0;
    endtask

    initial begin
        fpType g;
        fpType e;
        reset       = 1'b1;
        input_spike = '0;
        vmem        = '0;
        cfg_in      = '0;
        cfg_clk     = 1'b0;
        @(negedge clk);

        // ---- basic: one spike on ch0, tau=0 holds gsyn0=0x0100 ----
        start(64'h0000_0000_0000_1000, 64'h0000_0000_0000_0100, 64'h0);
        check("rst_cur",    {16'd0, output_current}, 32'd0);
        check("rst_valid",  {31'd0, cur_valid},      32'd0);
        check("rst_merged", {31'd0, spike_merged},   32'd0);
        reset = 1'b0;
        run_frame("basic_f0", 16'h0000, 16'h0001);
        run_frame("basic_f1", 16'h0800, 16'h0000);
        run_frame("basic_f2", 16'h0800, 16'h0000);

        // ---- reset in the middle of a frame ----
        step();
        step();
        reset = 1'b1;
        step();
        check("midrst_cur",   {16'd0, output_current}, 32'd0);
        check("midrst_valid", {31'd0, cur_valid},      32'd0);
        reset = 1'b0;
        run_frame("midrst_f0", 16'h0000, 16'h0000);

        // ---- decay: gsyn0 halves each service and floors at 1 -> 0 ----
        // E_rev0=0x0200, vmem=0 makes the frame current equal gsyn0.
        vmem = '0;
        start(64'h0000_0000_0000_0200, 64'h0000_0000_0000_8000, 64'h0000_0000_0000_4000);
        reset = 1'b0;
        run_frame("decay_f0", 16'h0000, 16'h0001);
        g = 16'h8000;
        for (int f = 1; f <= 18; f++) begin
            e = (g > 16'h7FFF) ? 16'h7FFF : g;
            run_frame($sformatf("decay_f%0d", f), e, 16'h0000);
            g = (g == 16'h0001) ? 16'h0000 : (g >> 1);
        end

        // ---- saturation: weight1=0xFFFF twice, large positive drive ----
        vmem = 16'h8000;
        start(64'h0000_0000_7FFF_0000, 64'h0000_0000_FFFF_0000, 64'h0);
        reset = 1'b0;
        run_frame("sat_f0", 16'h0000, 16'h0020);
        run_frame("sat_f1", 16'h7FFF, 16'h0020);
        run_frame("sat_f2", 16'h7FFF, 16'h0000);

        // weight1=0xC000 twice: 0xC000 then 0xFFFF (not wrapped to 0x8000).
        // diff=0x00FF: 0xC000*255>>9 = 0x5FA0, 0xFFFF*255>>9 = 0x7F7F.
        vmem = 16'h7F00;
        start(64'h0000_0000_7FFF_0000, 64'h0000_0000_C000_0000, 64'h0);
        reset = 1'b0;
        run_frame("satg_f0", 16'h0000, 16'h0020);
        run_frame("satg_f1", 16'h5FA0, 16'h0020);
        run_frame("satg_f2", 16'h7F7F, 16'h0000);

        // ---- negative current: E_rev0=0, vmem=0x1000 ----
        vmem = 16'h1000;
        start(64'h0, 64'h0000_0000_0000_0100, 64'h0);
        reset = 1'b0;
        run_frame("neg_f0", 16'h0000, 16'h0001);
        run_frame("neg_f1", 16'hF800, 16'h0000);

        // ---- merge: two ch2 spikes before its service count once ----
        vmem = '0;
        start(64'h0000_0200_0000_0000, 64'h0000_0010_0000_0000, 64'h0);
        reset = 1'b0;
        input_spike = 4'b0100;
        step();
        check("merge_k0", {31'd0, spike_merged}, 32'd0);
        step();
        check("merge_k1", {31'd0, spike_merged}, 32'd1);
        input_spike = '0;
        step();
        check("merge_k2", {31'd0, spike_merged}, 32'd0);
        step();
        check("merge_f0_valid", {31'd0, cur_valid}, 32'd1);
        check("merge_f0_cur", {16'd0, output_current}, 32'd0);
        // Spike on ch2's own service cycle is applied in that service.
        run_frame("merge_f1", 16'h0010, 16'h0400);
        check("merge_own_nomerge", {31'd0, spike_merged}, 32'd0);
        run_frame("merge_f2", 16'h0020, 16'h0000);

        // ---- config chain: words 1..12, first word lands in tau[3] ----
        reset = 1'b1;
        for (int k = 1; k <= 12; k++)
            cfg_shift(fpType'(k));
        check("cfg_out12", {16'd0, cfg_out}, 32'd1);
        // E_rev0=12, weight0=11, tau0=10; vmem=-32768:
        // (12+32768)*11 >>> 9 = 0x02C0.
        vmem = 16'h8000;
        step();
        step();
        reset = 1'b0;
        run_frame("cfg_f0", 16'h0000, 16'h0001);
        run_frame("cfg_f1", 16'h02C0, 16'h0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
